// File: rtl/led_breath_driver_pkg.sv
// Shared LED driver definitions: mode and FSM state encodings reused by
// other status-LED users in the system top.
package led_breath_driver_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD_HI   = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_HOLD_LO   = 3'd4,
    ST_BLINK     = 3'd5
  } state_t;

endpackage

// File: rtl/led_breath_driver_tick_gen.sv
// Timebase prescaler: counts 0..DIV-1 and pulses tick for one cycle at DIV-1.
// clear holds the count at zero and suppresses the tick.
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("tick_gen: DIV must be >= 2");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/led_breath_driver.sv
// Mode-selectable LED driver (off / on / blink / breathe) with a tick
// prescaler, free-running PWM counter and a duty ramping FSM.
module led_breath_driver
  import led_breath_driver_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 80000000,
  parameter int unsigned STEP_HZ     = 1000,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned HOLD_STEPS  = 256,
  parameter int unsigned BLINK_STEPS = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] mode,
  output logic       led,
  output logic [2:0] phase
);

  localparam int unsigned DIV = CLK_FREQ / STEP_HZ;
  localparam int unsigned HW  = $clog2(HOLD_STEPS + 1);
  localparam int unsigned BW  = $clog2(BLINK_STEPS + 1);
  localparam logic [PWM_BITS-1:0] MAXD       = '1;
  localparam logic [HW-1:0]       HOLD_LAST  = HW'(HOLD_STEPS - 1);
  localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_STEPS - 1);

  if (DIV < 2 || HOLD_STEPS < 1 || BLINK_STEPS < 1) begin : g_bad_params
    $error("led_breath_driver: need DIV>=2, HOLD_STEPS>=1, BLINK_STEPS>=1");
  end

  state_t              state, state_n;
  mode_t               mode_q;
  logic [PWM_BITS-1:0] duty, duty_n, pwm_cnt;
  logic [HW-1:0]       hold_cnt, hold_n;
  logic [BW-1:0]       blink_cnt, blink_n;
  logic                blink_q, blink_q_n;
  logic                led_n, pwm_on, abort, tick, tick_clear;

  // A mode change or enable drop restarts everything from IDLE on the next cycle.
  assign abort      = !enable || (mode != mode_q);
  assign tick_clear = abort || (state == ST_IDLE);
  assign pwm_on     = pwm_cnt < duty;
  assign phase      = state;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  always_comb begin
    state_n   = state;
    duty_n    = duty;
    hold_n    = hold_cnt;
    blink_n   = blink_cnt;
    blink_q_n = blink_q;
    if (abort) begin
      state_n   = ST_IDLE;
      duty_n    = '0;
      hold_n    = '0;
      blink_n   = '0;
      blink_q_n = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (mode_q == MODE_BREATHE)    state_n = ST_RAMP_UP;
          else if (mode_q == MODE_BLINK) state_n = ST_BLINK;
        end
        ST_RAMP_UP: if (tick) begin
          duty_n = (duty == MAXD) ? MAXD : duty + 1'b1;
          if (duty_n == MAXD) state_n = ST_HOLD_HI;
        end
        ST_HOLD_HI, ST_HOLD_LO: if (tick) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_n  = '0;
            state_n = (state == ST_HOLD_HI) ? ST_RAMP_DOWN : ST_RAMP_UP;
          end else begin
            hold_n = hold_cnt + 1'b1;
          end
        end
        ST_RAMP_DOWN: if (tick) begin
          duty_n = (duty == '0) ? '0 : duty - 1'b1;
          if (duty_n == '0) state_n = ST_HOLD_LO;
        end
        ST_BLINK: if (tick) begin
          if (blink_cnt == BLINK_LAST) begin
            blink_n   = '0;
            blink_q_n = !blink_q;
          end else begin
            blink_n = blink_cnt + 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    led_n = 1'b0;
    if (enable) begin
      unique case (mode_q)
        MODE_OFF:     led_n = 1'b0;
        MODE_ON:      led_n = 1'b1;
        MODE_BLINK:   led_n = blink_q;
        MODE_BREATHE: led_n = pwm_on;
        default:      led_n = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_OFF;
      duty      <= '0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      blink_q   <= 1'b0;
      pwm_cnt   <= '0;
      led       <= 1'b0;
    end else begin
      state     <= state_n;
      mode_q    <= mode_t'(mode);
      duty      <= duty_n;
      hold_cnt  <= hold_n;
      blink_cnt <= blink_n;
      blink_q   <= blink_q_n;
      pwm_cnt   <= pwm_cnt + 1'b1;
      led       <= led_n;
    end
  end

endmodule

// File: tb/tb_led_breath_driver.sv
// Randomized bench for led_breath_driver: a closed-form model computes
// expected led/phase from elapsed ticks since each run started.
module tb_led_breath_driver;

  localparam int unsigned DIV  = 10;
  localparam int unsigned MAXD = 15;
  localparam int unsigned HOLD = 2;
  localparam int unsigned BLNK = 3;
  localparam int unsigned PER  = 2 * MAXD + 2 * HOLD;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] mode;
  logic       led;
  logic [2:0] phase;

  int unsigned total = 0;
  int unsigned bad   = 0;

  led_breath_driver #(
    .CLK_FREQ    (1000),
    .STEP_HZ     (100),
    .PWM_BITS    (4),
    .HOLD_STEPS  (HOLD),
    .BLINK_STEPS (BLNK)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .led    (led),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  // Model state: run kind 0=idle, 1=breathe, 2=blink; start = edge index of run entry.
  int unsigned k = 0, pc = 0, mq = 0, run = 0, start = 0;
  int unsigned exp_led = 0, cur_phase = 0, cur_duty = 0, cur_bq = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0d exp=%0d", tag, k, got, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit en, input int unsigned md);
    int unsigned n, p;
    k++;
    if (rst) begin
      exp_led = 0; mq = 0; run = 0; pc = 0;
    end else begin
      if (!en)          exp_led = 0;
      else if (mq == 1) exp_led = 1;
      else if (mq == 2) exp_led = cur_bq;
      else if (mq == 3) exp_led = (pc < cur_duty) ? 1 : 0;
      else              exp_led = 0;
      pc = (pc + 1) % (MAXD + 1);
      if (!en || md != mq) run = 0;
      else if (run == 0 && mq == 3) begin run = 1; start = k; end
      else if (run == 0 && mq == 2) begin run = 2; start = k; end
      mq = md;
    end
    cur_phase = 0; cur_duty = 0; cur_bq = 0;
    if (run != 0) begin
      n = (k - start) / DIV;
      if (run == 2) begin
        cur_phase = 5;
        cur_bq = (n / BLNK) % 2;
      end else begin
        p = n % PER;
        if (p < MAXD) begin
          cur_phase = 1; cur_duty = p;
        end else if (p < MAXD + HOLD) begin
          cur_phase = 2; cur_duty = MAXD;
        end else if (p < 2 * MAXD + HOLD) begin
          cur_phase = 3; cur_duty = MAXD - (p - MAXD - HOLD);
        end else begin
          cur_phase = 4; cur_duty = 0;
        end
      end
    end
  endtask

  task automatic run_cycles(input bit rst, input bit en, input logic [1:0] md, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      reset = rst; enable = en; mode = md;
      @(posedge clk);
      #1;
      model_edge(rst, en, md);
      check_eq("led", led, exp_led);
      check_eq("phase", phase, cur_phase);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; mode = 2'd1;
    run_cycles(1'b1, 1'b1, 2'd1, 3);
    run_cycles(1'b0, 1'b1, 2'd1, 5);
    run_cycles(1'b0, 1'b1, 2'd0, 5);
    run_cycles(1'b0, 1'b1, 2'd2, 200);
    run_cycles(1'b0, 1'b1, 2'd3, 400);
    for (int s = 0; s < 50; s++) begin
      if ($urandom_range(0, 19) == 0)
        run_cycles(1'b1, 1'(($urandom % 2)), 2'($urandom % 4), $urandom_range(1, 3));
      else
        run_cycles(1'b0, ($urandom % 8) != 0, 2'($urandom % 4), $urandom_range(1, 400));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
